// File: rtl/seq_pkg.sv
// Shared types and constants for the Y86-64 SEQ stage sequencer:
// the stage state, processor status codes, icode values and the memory-path decode.
package seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXECUTE,
        MEMORY,
        WRITEBACK,
        PCUPDATE,
        HALT
    } state_t;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [3:0] ICODE_HALT   = 4'h0;
    localparam logic [3:0] ICODE_NOP    = 4'h1;
    localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
    localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
    localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
    localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
    localparam logic [3:0] ICODE_OPQ    = 4'h6;
    localparam logic [3:0] ICODE_JXX    = 4'h7;
    localparam logic [3:0] ICODE_CALL   = 4'h8;
    localparam logic [3:0] ICODE_RET    = 4'h9;
    localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
    localparam logic [3:0] ICODE_POPQ   = 4'hB;

    // Instructions that touch data memory (loads, stores and stack traffic).
    function automatic logic needs_mem(input logic [3:0] ic);
        logic result;
        result = 1'b0;
        case (ic)
            ICODE_RMMOVQ, ICODE_MRMOVQ, ICODE_CALL,
            ICODE_RET, ICODE_PUSHQ, ICODE_POPQ:  result = 1'b1;
            ICODE_HALT, ICODE_NOP, ICODE_RRMOVQ,
            ICODE_IRMOVQ, ICODE_OPQ, ICODE_JXX:  result = 1'b0;
            default:                             result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/seq_mem_wait_timer.sv
// Counts consecutive data-memory wait cycles and flags the cycle in which
// the MEM_TIMEOUT-th wait occurs; MEM_TIMEOUT = 0 disables the timer.
module seq_mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expire
);

    generate
        if (MEM_TIMEOUT == 0) begin : g_off
            assign expire = 1'b0;
        end else begin : g_on
            localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

            logic [CW-1:0] cnt_reg;

            // Expiry looks at the count before this cycle's increment, so it
            // fires on the wait cycle that brings the total to MEM_TIMEOUT.
            assign expire = en && (cnt_reg == CW'(MEM_TIMEOUT - 1));

            always_ff @(posedge clk) begin
                if (rst || clear) begin
                    cnt_reg <= '0;
                end else if (en && !expire) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/seq_stage_ctrl.sv
// Multi-cycle stage sequencer for the Y86-64 SEQ datapath: one stage enable per cycle.
// Define SEQ_CTRL_PERF_EN to add the saturating cycle_cnt / instr_cnt performance counters.
module seq_stage_ctrl
    import seq_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
`ifdef SEQ_CTRL_PERF_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [3:0] icode,
    input  logic       instr_valid,
    input  logic       imem_error,
    output logic       dmem_req,
    input  logic       dmem_ready,
    input  logic       dmem_error,
    output logic       fetch_en,
    output logic       decode_en,
    output logic       exec_en,
    output logic       mem_en,
    output logic       wb_en,
    output logic       pc_en,
    output logic [2:0] stat,
    output logic       halted,
    output logic       retired
`ifdef SEQ_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
`endif
);

    state_t     state_reg;
    logic [3:0] icode_q_reg;
    logic [2:0] stat_reg;
    logic       retired_reg;
    logic       mem_wait;
    logic       mem_clear;
    logic       mem_expire;

    assign mem_wait  = (state_reg == MEMORY) && !dmem_ready;
    assign mem_clear = (state_reg != MEMORY) || dmem_ready;

    seq_mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (mem_clear),
        .en    (mem_wait),
        .expire(mem_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            icode_q_reg <= ICODE_HALT;
            stat_reg    <= STAT_AOK;
            retired_reg <= 1'b0;
        end else begin
            retired_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (run) state_reg <= FETCH;
                end
                FETCH: begin
                    icode_q_reg <= icode;
                    if (imem_error) begin
                        stat_reg  <= STAT_ADR;
                        state_reg <= HALT;
                    end else if (!instr_valid) begin
                        stat_reg  <= STAT_INS;
                        state_reg <= HALT;
                    end else if (icode == ICODE_HALT) begin
                        // halt itself retires; the pulse lands in the first HALT cycle
                        stat_reg    <= STAT_HLT;
                        retired_reg <= 1'b1;
                        state_reg   <= HALT;
                    end else begin
                        state_reg <= DECODE;
                    end
                end
                DECODE: state_reg <= EXECUTE;
                EXECUTE: begin
                    state_reg <= needs_mem(icode_q_reg) ? MEMORY : WRITEBACK;
                end
                MEMORY: begin
                    if (dmem_ready) begin
                        if (dmem_error) begin
                            stat_reg  <= STAT_ADR;
                            state_reg <= HALT;
                        end else begin
                            state_reg <= WRITEBACK;
                        end
                    end else if (mem_expire) begin
                        stat_reg  <= STAT_ADR;
                        state_reg <= HALT;
                    end
                end
                WRITEBACK: begin
                    // Registered so the pulse coincides with pc_en
                    retired_reg <= 1'b1;
                    state_reg   <= PCUPDATE;
                end
                PCUPDATE: state_reg <= run ? FETCH : IDLE;
                HALT:     state_reg <= HALT;
                default:  state_reg <= IDLE;
            endcase
        end
    end

    assign fetch_en  = (state_reg == FETCH);
    assign decode_en = (state_reg == DECODE);
    assign exec_en   = (state_reg == EXECUTE);
    assign mem_en    = (state_reg == MEMORY);
    assign wb_en     = (state_reg == WRITEBACK);
    assign pc_en     = (state_reg == PCUPDATE);
    assign dmem_req  = (state_reg == MEMORY);
    assign halted    = (state_reg == HALT);
    assign stat      = stat_reg;
    assign retired   = retired_reg;

`ifdef SEQ_CTRL_PERF_EN
    logic [CNT_W-1:0] cycle_cnt_reg;
    logic [CNT_W-1:0] instr_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt_reg <= '0;
            instr_cnt_reg <= '0;
        end else begin
            if ((state_reg != IDLE) && (state_reg != HALT) && !(&cycle_cnt_reg)) begin
                cycle_cnt_reg <= cycle_cnt_reg + 1'b1;
            end
            if (retired_reg && !(&instr_cnt_reg)) begin
                instr_cnt_reg <= instr_cnt_reg + 1'b1;
            end
        end
    end

    assign cycle_cnt = cycle_cnt_reg;
    assign instr_cnt = instr_cnt_reg;
`endif

endmodule

// File: tb/tb_seq_stage_ctrl.sv
// Testbench for seq_stage_ctrl: table-driven instruction vectors, hand-written corner
// sequences and random instructions checked against a stage-list model.
module tb_seq_stage_ctrl;

    localparam int TO = 16;
    // Stage codes used by the model: 0 = none, 1..6 = F D E M W P
    localparam int S_NONE = 0, S_F = 1, S_D = 2, S_E = 3, S_M = 4, S_W = 5, S_P = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic [3:0] icode = 4'h0;
    logic       instr_valid = 1'b0;
    logic       imem_error = 1'b0;
    logic       dmem_req;
    logic       dmem_ready = 1'b0;
    logic       dmem_error = 1'b0;
    logic       fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en;
    logic [2:0] stat;
    logic       halted;
    logic       retired;
`ifdef SEQ_CTRL_PERF_EN
    logic [31:0] cycle_cnt;
    logic [31:0] instr_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    seq_stage_ctrl #(
        .MEM_TIMEOUT(TO)
`ifdef SEQ_CTRL_PERF_EN
        ,
        .CNT_W(32)
`endif
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .icode      (icode),
        .instr_valid(instr_valid),
        .imem_error (imem_error),
        .dmem_req   (dmem_req),
        .dmem_ready (dmem_ready),
        .dmem_error (dmem_error),
        .fetch_en   (fetch_en),
        .decode_en  (decode_en),
        .exec_en    (exec_en),
        .mem_en     (mem_en),
        .wb_en      (wb_en),
        .pc_en      (pc_en),
        .stat       (stat),
        .halted     (halted),
        .retired    (retired)
`ifdef SEQ_CTRL_PERF_EN
        ,
        .cycle_cnt  (cycle_cnt),
        .instr_cnt  (instr_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] ic;
        bit         valid;
        bit         imerr;
        int         waits;
        bit         derr;
        bit         keep_run;
        logic [2:0] exp_stat;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [3:0] ic, input bit valid, input bit imerr,
                                input int waits, input bit derr, input bit keep_run,
                                input logic [2:0] exp_stat);
        vec_t v;
        v.ic = ic; v.valid = valid; v.imerr = imerr; v.waits = waits;
        v.derr = derr; v.keep_run = keep_run; v.exp_stat = exp_stat;
        return v;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // {fetch, decode, exec, mem, wb, pc, dmem_req, retired, halted}
    function automatic logic [31:0] obs();
        return {23'd0, fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en,
                dmem_req, retired, halted};
    endfunction

    function automatic logic [31:0] exp_obs(input int s, input bit ret, input bit hlt);
        logic [5:0] en;
        en = (s >= S_F && s <= S_P) ? (6'b100000 >> (s - 1)) : 6'b0;
        return {23'd0, en, (s == S_M), ret, hlt};
    endfunction

    function automatic bit is_mem(input logic [3:0] ic);
        return ic == 4'h4 || ic == 4'h5 || ic == 4'h8 || ic == 4'h9 || ic == 4'hA || ic == 4'hB;
    endfunction

    // Reset, confirm the reset state and an IDLE hold, then start so the DUT sits in FETCH.
    task automatic reset_start;
        rst = 1'b1; run = 1'b1; dmem_ready = 1'b1; icode = 4'h4; instr_valid = 1'b1;
        tick;
        tick;
        check("reset_obs", obs(), 32'd0);
        check("reset_stat", {29'd0, stat}, 32'd1);
        rst = 1'b0; run = 1'b0;
        tick;
        check("idle_hold", obs(), 32'd0);
        run = 1'b1;
        tick;
    endtask

    // Runs one instruction starting in FETCH; the expected stage list is built from the rules.
    task automatic do_instr(input logic [3:0] ic, input bit valid, input bit imerr,
                            input int waits, input bit derr, input bit keep_run,
                            output bit halts, output logic [2:0] fstat);
        int  seq[$];
        int  mi;
        bit  ret_halt;
        halts = 0; fstat = 3'd1; ret_halt = 0; mi = 0;
        seq.push_back(S_F);
        if (imerr) begin
            halts = 1; fstat = 3'd3;
        end else if (!valid) begin
            halts = 1; fstat = 3'd4;
        end else if (ic == 4'h0) begin
            halts = 1; fstat = 3'd2; ret_halt = 1;
        end else begin
            seq.push_back(S_D);
            seq.push_back(S_E);
            if (is_mem(ic)) begin
                if (waits >= TO) begin
                    repeat (TO) seq.push_back(S_M);
                    halts = 1; fstat = 3'd3;
                end else begin
                    repeat (waits + 1) seq.push_back(S_M);
                    if (derr) begin
                        halts = 1; fstat = 3'd3;
                    end
                end
            end
            if (!halts) begin
                seq.push_back(S_W);
                seq.push_back(S_P);
            end
        end

        foreach (seq[i]) begin
            if (seq[i] == S_F) begin
                icode = ic; instr_valid = valid; imem_error = imerr;
            end else begin
                icode = 4'($urandom); instr_valid = 1'($urandom); imem_error = 1'($urandom);
            end
            if (seq[i] == S_M) begin
                dmem_ready = (mi == waits);
                dmem_error = (mi == waits) ? derr : 1'($urandom);
                mi++;
            end else begin
                dmem_ready = 1'($urandom);
                dmem_error = 1'($urandom);
            end
            run = keep_run ? 1'b1 : (seq[i] < S_E);
            check($sformatf("ic%0h_cyc%0d", ic, i + 1), obs(), exp_obs(seq[i], seq[i] == S_P, 0));
            tick;
        end

        if (halts) begin
            check($sformatf("ic%0h_halt_obs", ic), obs(), exp_obs(S_NONE, ret_halt, 1));
            check($sformatf("ic%0h_halt_stat", ic), {29'd0, stat}, {29'd0, fstat});
            run = 1'b1;
            tick;
            check($sformatf("ic%0h_halt_hold", ic), obs(), exp_obs(S_NONE, 0, 1));
        end else if (keep_run) begin
            check($sformatf("ic%0h_next_fetch", ic), obs(), exp_obs(S_F, 0, 0));
            check($sformatf("ic%0h_stat", ic), {29'd0, stat}, 32'd1);
        end else begin
            check($sformatf("ic%0h_to_idle", ic), obs(), 32'd0);
            run = 1'b1;
            tick;
        end
    endtask

    initial begin
        bit         h;
        logic [2:0] fs;

        tbl.push_back(mk(4'h6, 1, 0, 0,  0, 1, 3'd1));
        tbl.push_back(mk(4'h5, 1, 0, 2,  0, 1, 3'd1));
        tbl.push_back(mk(4'h1, 1, 0, 0,  0, 1, 3'd1));
        tbl.push_back(mk(4'h7, 1, 0, 0,  0, 0, 3'd1));
        tbl.push_back(mk(4'h2, 1, 0, 0,  0, 1, 3'd1));
        tbl.push_back(mk(4'h4, 1, 0, 0,  0, 1, 3'd1));
        tbl.push_back(mk(4'h8, 1, 0, 1,  0, 0, 3'd1));
        tbl.push_back(mk(4'hA, 1, 0, 15, 0, 1, 3'd1));
        tbl.push_back(mk(4'hB, 1, 0, 3,  0, 1, 3'd1));
        tbl.push_back(mk(4'h6, 0, 1, 0,  0, 1, 3'd3));
        tbl.push_back(mk(4'h6, 0, 0, 0,  0, 1, 3'd4));
        tbl.push_back(mk(4'h0, 1, 1, 0,  0, 1, 3'd3));
        tbl.push_back(mk(4'h0, 1, 0, 0,  0, 1, 3'd2));
        tbl.push_back(mk(4'hA, 1, 0, 16, 0, 1, 3'd3));
        tbl.push_back(mk(4'h9, 1, 0, 1,  1, 1, 3'd3));

        reset_start;
        foreach (tbl[k]) begin
            do_instr(tbl[k].ic, tbl[k].valid, tbl[k].imerr, tbl[k].waits,
                     tbl[k].derr, tbl[k].keep_run, h, fs);
            check($sformatf("tbl%0d_stat", k), {29'd0, stat}, {29'd0, tbl[k].exp_stat});
`ifdef SEQ_CTRL_PERF_EN
            if (k == 0) begin
                check("perf_instr_cnt", instr_cnt, 32'd1);
                check("perf_cycle_cnt", cycle_cnt, 32'd5);
            end
`endif
            if (h) reset_start;
        end

        // halt then a long run=1 stretch: nothing may restart
        reset_start;
        do_instr(4'h0, 1, 0, 0, 0, 1, h, fs);
        for (int i = 0; i < 20; i++) begin
            run = 1'b1;
            tick;
            check("halt_run_hold", obs(), exp_obs(S_NONE, 0, 1));
        end

        // reset in the middle of a MEMORY wait
        reset_start;
        icode = 4'h5; instr_valid = 1'b1; imem_error = 1'b0; dmem_ready = 1'b0;
        tick;
        tick;
        tick;
        check("midmem_in_mem", obs(), exp_obs(S_M, 0, 0));
        rst = 1'b1;
        tick;
        check("midmem_rst_obs", obs(), 32'd0);
        check("midmem_rst_stat", {29'd0, stat}, 32'd1);
        rst = 1'b0; run = 1'b0;
        tick;
        check("midmem_idle", obs(), 32'd0);

        // random instructions against the stage-list model
        run = 1'b1;
        tick;
        for (int k = 0; k < 60; k++) begin
            logic [3:0] ic;
            bit v, ie, de, kr;
            int w;
            ic = 4'($urandom_range(1, 11));
            if ($urandom_range(0, 19) == 0) ic = 4'h0;
            v  = ($urandom_range(0, 15) != 0);
            ie = ($urandom_range(0, 24) == 0);
            w  = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 18) : $urandom_range(0, 3);
            de = ($urandom_range(0, 9) == 0);
            kr = ($urandom_range(0, 5) != 0);
            do_instr(ic, v, ie, w, de, kr, h, fs);
            if (h) reset_start;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_stage_ctrl.md
Name: seq_stage_ctrl

Overview:
Multi-cycle stage sequencer for the Y86-64 SEQ datapath. It steps one instruction at a time through FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK and PCUPDATE, asserting one stage enable per cycle. It waits on a data-memory handshake and tracks processor status (AOK/HLT/ADR/INS). It sits above the Fetch/Decode/Execute/Memory/Writeback blocks and is the only source of their enables.

Parameters:
MEM_TIMEOUT, 16, consecutive MEMORY cycles with dmem_ready low before an ADR fault; 0 disables the timeout
CNT_W, 32, width of performance counters (used only with SEQ_CTRL_PERF_EN)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset; synchronous, active-high
run  input  1  permit execution; sampled in IDLE and PCUPDATE
icode  input  4  instruction code from fetch; latched at end of FETCH into icode_q
instr_valid  input  1  fetch reports a legal icode/ifun
imem_error  input  1  fetch address fault
dmem_req  output  1  memory access request; high in every MEMORY cycle
dmem_ready  input  1  memory access completes this cycle; ignored outside MEMORY
dmem_error  input  1  data address fault; qualified by dmem_ready
fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en  output  1 each  one-hot stage enables
stat  output  3  1=AOK, 2=HLT, 3=ADR, 4=INS
halted  output  1  high while in HALT
retired  output  1  one-cycle pulse when an instruction completes

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, icode_q=0, all enables 0, dmem_req=0, stat=1, halted=0, retired=0, timeout counter=0. rst overrides every other input, including in mid-instruction.
- Registered state. Enables, dmem_req and halted are decoded from state only, so there is no input-to-output combinational path.
- IDLE: goes to FETCH when run=1; otherwise stays.
- FETCH (fetch_en=1): fault priority is imem_error > !instr_valid > halt.
  - imem_error=1 -> stat=3, go to HALT.
  - else instr_valid=0 -> stat=4, go to HALT.
  - else icode=0 (halt) -> stat=2, retired=1 at the same edge, go to HALT.
  - else go to DECODE.
- DECODE -> EXECUTE, unconditionally.
- EXECUTE -> MEMORY if icode_q is 4, 5, 8, 9, A or B; else -> WRITEBACK. nop (1) and jXX (7) take the WRITEBACK path.
- MEMORY (mem_en=1, dmem_req=1):
  - dmem_ready=1 & dmem_error=1 -> stat=3, go to HALT.
  - dmem_ready=1 & dmem_error=0 -> go to WRITEBACK.
  - dmem_ready=0 -> increment the timeout counter. If MEM_TIMEOUT≠0 and this is the MEM_TIMEOUT-th consecutive wait cycle -> stat=3, go to HALT.
  - dmem_ready=1 in the expiry cycle: ready wins.
  - The counter clears on MEMORY exit.
- WRITEBACK -> PCUPDATE.
- PCUPDATE (pc_en=1): retired=1; go to FETCH if run=1, else IDLE.
- HALT: no enables; stays until rst; run is ignored.
- run deasserted mid-instruction: the instruction finishes through PCUPDATE, then the FSM goes to IDLE.
- Latency: 5 cycles per non-memory instruction; 6+N cycles for a memory instruction with N wait cycles.
- stat changes only on a transition into HALT, or on reset.

Optional Feature:
SEQ_CTRL_PERF_EN defined:
- Adds output cycle_cnt [CNT_W-1:0]: increments every cycle the state is not IDLE or HALT.
- Adds output instr_cnt [CNT_W-1:0]: increments on each retired pulse.
- Both saturate at all-ones and reset to 0.
Not defined: neither port nor its logic exists; behaviour is otherwise identical.

Decomposition:
- Package seq_pkg holds:
  - state enum: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPDATE, HALT
  - STAT_AOK/HLT/ADR/INS constants
  - ICODE_HALT..ICODE_POPQ constants
  - function needs_mem(icode)
- One sub-module: seq_mem_wait_timer (clear/enable/expire counter, parameter MEM_TIMEOUT).

Test Plan:
1. Reset, run=1, icode=6, instr_valid=1 -> fetch/decode/exec/wb/pc enables on cycles 1-5; retired on cycle 5; fetch_en on cycle 6; stat=1.
2. icode=5, dmem_ready raised on the 3rd MEMORY cycle -> dmem_req high 3 cycles; retired on cycle 8; mem_en never overlaps other enables.
3. icode=0 -> stat=2, halted=1 after FETCH, retired pulses once. With run held at 1 for 20 cycles -> no enables. rst -> stat=1, IDLE.
4. imem_error=1 and instr_valid=0 together -> stat=3. Separately, instr_valid=0 alone -> stat=4. No retired pulse in either case.
5. icode=A, dmem_ready held low, MEM_TIMEOUT=16 -> HALT after the 16th MEMORY cycle with stat=3. Separately, dmem_ready=1 with dmem_error=1 -> stat=3 next cycle.
6. run dropped in EXECUTE -> instruction retires, then IDLE. rst asserted mid-MEMORY -> IDLE, dmem_req=0 the next cycle. With SEQ_CTRL_PERF_EN, after test 1, instr_cnt=1 and cycle_cnt=5.
